rtc_clock_core: RTL and testbench

Parametrised real-time clock core for the Tiny Tapeout clock designs. It adds the following over the fixed 12-hour counter:
- Built-in second prescaler.
- Runtime 12h/24h display mode.
- Validated time-set port.
- Armable alarm with sticky pending flag.

Time is held internally in canonical 24h form. A top-level wrapper maps the outputs onto uo_out/uio_out.

---
 rtl/rtc_pkg.sv | 41 ++++
 rtl/rtc_clock_core_prescaler.sv | 23 ++
 rtl/rtc_clock_core.sv | 120 ++++++++++++
 tb/tb_rtc_clock_core.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants, time record and hour-encoding helpers for the RTC core.
// Hours are stored canonically as 0..23; the helpers convert to and from the display encoding.
package rtc_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HR24_MAX = 5'd23;
  localparam logic [4:0] HR12_MAX = 5'd12;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } rtc_time_t;

  // Returns {valid, canonical_hour}; 12 AM maps to 0 and 12 PM to 12.
  function automatic logic [5:0] to_canon_hour(input logic [4:0] h, input logic pm,
                                               input logic mode_24h);
    logic       ok;
    logic [4:0] hc;
    if (mode_24h) begin
      ok = (h <= HR24_MAX);
      hc = h;
    end else begin
      ok = (h != 5'd0) && (h <= HR12_MAX);
      if (h == HR12_MAX) hc = pm ? HR12_MAX : 5'd0;
      else               hc = pm ? h + HR12_MAX : h;
    end
    return {ok, hc};
  endfunction

  // Returns {display_hour, pm}.
  function automatic logic [5:0] to_disp_hour(input logic [4:0] h, input logic mode_24h);
    logic [4:0] m;
    if (mode_24h) return {h, 1'b0};
    m = (h >= HR12_MAX) ? h - HR12_MAX : h;
    if (m == 5'd0) m = HR12_MAX;
    return {m, (h >= HR12_MAX)};
  endfunction

endpackage

// File: rtl/rtc_clock_core_prescaler.sv
// Second prescaler: counts 0..TICK_DIV-1 while enabled, ticks on the last count.
module rtc_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (tick)   cnt <= '0;
    else if (en)     cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/rtc_clock_core.sv
// Real-time clock core: canonical 24h time, runtime 12h/24h display,
// validated time set and an armable alarm with a sticky pending flag.
module rtc_clock_core
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter bit ALARM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode_24h,
  input  logic       set_valid,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  input  logic       set_pm,
  output logic       set_err,
  input  logic       alarm_wr,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_pm,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic       sec_tick,
  output logic       alarm_fire,
  output logic       alarm_pending
);
  rtc_time_t  cur, nxt;
  logic       tick, adv;
  logic [5:0] set_hc;
  logic       set_ok, set_bad, alm_bad;

  rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (set_ok),
    .tick(tick)
  );

  always_comb begin
    set_hc  = to_canon_hour(set_hours, set_pm, mode_24h);
    set_ok  = set_valid && set_hc[5] && (set_minutes <= MIN_MAX) && (set_seconds <= SEC_MAX);
    set_bad = set_valid && !set_ok;
    // A valid set in the same cycle swallows the tick.
    adv     = tick && !set_ok;
  end

  always_comb begin
    nxt = cur;
    if (cur.sec == SEC_MAX) begin
      nxt.sec = '0;
      if (cur.min == MIN_MAX) begin
        nxt.min  = '0;
        nxt.hour = (cur.hour == HR24_MAX) ? 5'd0 : cur.hour + 5'd1;
      end else begin
        nxt.min = cur.min + 6'd1;
      end
    end else begin
      nxt.sec = cur.sec + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= '0;
      sec_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      if (set_ok)   cur <= '{hour: set_hc[4:0], min: set_minutes, sec: set_seconds};
      else if (adv) cur <= nxt;
      sec_tick <= adv;
      set_err  <= set_bad || alm_bad;
    end
  end

  assign {hours, pm} = to_disp_hour(cur.hour, mode_24h);
  assign minutes     = cur.min;
  assign seconds     = cur.sec;

  if (ALARM_EN) begin : g_alarm
    logic [4:0] alm_h;
    logic [5:0] alm_m;
    logic [5:0] alm_hc;
    logic       alm_ok, match;

    always_comb begin
      alm_hc  = to_canon_hour(alarm_hours, alarm_pm, mode_24h);
      alm_ok  = alarm_wr && alm_hc[5] && (alarm_minutes <= MIN_MAX);
      alm_bad = alarm_wr && !alm_ok;
      match   = adv && alarm_arm && (nxt.hour == alm_h) && (nxt.min == alm_m) && (nxt.sec == 6'd0);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        alm_h         <= '0;
        alm_m         <= '0;
        alarm_fire    <= 1'b0;
        alarm_pending <= 1'b0;
      end else begin
        if (alm_ok) begin
          alm_h <= alm_hc[4:0];
          alm_m <= alarm_minutes;
        end
        alarm_fire <= match;
        // An ack overlapping a fire (match cycle or pulse cycle) loses to it.
        alarm_pending <= match || alarm_fire || (alarm_pending && !alarm_ack);
      end
    end
  end else begin : g_no_alarm
    assign alm_bad       = 1'b0;
    assign alarm_fire    = 1'b0;
    assign alarm_pending = 1'b0;
  end
endmodule

// File: tb/tb_rtc_clock_core.sv
// Directed bench for rtc_clock_core with TICK_DIV=4; expected values are hand-computed.
module tb_rtc_clock_core;
  logic       clk = 1'b0;
  logic       rst, en, mode_24h;
  logic       set_valid, set_pm, set_err;
  logic [4:0] set_hours;
  logic [5:0] set_minutes, set_seconds;
  logic       alarm_wr, alarm_pm, alarm_arm, alarm_ack;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       pm, sec_tick, alarm_fire, alarm_pending;

  int total = 0;
  int bad   = 0;

  rtc_clock_core #(.TICK_DIV(4), .ALARM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_24h(mode_24h),
    .set_valid(set_valid), .set_hours(set_hours), .set_minutes(set_minutes),
    .set_seconds(set_seconds), .set_pm(set_pm), .set_err(set_err),
    .alarm_wr(alarm_wr), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_pm(alarm_pm), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .hours(hours), .minutes(minutes), .seconds(seconds), .pm(pm),
    .sec_tick(sec_tick), .alarm_fire(alarm_fire), .alarm_pending(alarm_pending)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".h"}, 32'(hours), 32'(h));
    chk({tag, ".m"}, 32'(minutes), 32'(m));
    chk({tag, ".s"}, 32'(seconds), 32'(s));
  endtask

  // Drive a one-cycle set strobe, optionally with a coincident alarm write.
  task automatic do_set(input int h, input int m, input int s, input logic p);
    set_valid = 1'b1; set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 6'(s); set_pm = p;
    cyc(1);
    set_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode_24h = 1'b0;
    set_valid = 1'b0; set_hours = '0; set_minutes = '0; set_seconds = '0; set_pm = 1'b0;
    alarm_wr = 1'b0; alarm_hours = '0; alarm_minutes = '0; alarm_pm = 1'b0;
    alarm_arm = 1'b0; alarm_ack = 1'b0;
    cyc(2);
    chk_time("rst12", 12, 0, 0);
    chk("rst.pm", 32'(pm), 0);
    chk("rst.set_err", 32'(set_err), 0);
    chk("rst.sec_tick", 32'(sec_tick), 0);
    chk("rst.fire", 32'(alarm_fire), 0);
    chk("rst.pending", 32'(alarm_pending), 0);
    mode_24h = 1'b1; #1;
    chk("rst24.h", 32'(hours), 0);

    // Prescaler: ticks on edges 4 and 8 after release.
    mode_24h = 1'b0; rst = 1'b0; en = 1'b1;
    cyc(3);
    chk("presc.no_tick", 32'(sec_tick), 0);
    chk("presc.s0", 32'(seconds), 0);
    cyc(1);
    chk("presc.tick1", 32'(sec_tick), 1);
    chk("presc.s1", 32'(seconds), 1);
    cyc(1);
    chk("presc.tick_pulse", 32'(sec_tick), 0);
    cyc(3);
    chk("presc.tick2", 32'(sec_tick), 1);
    chk_time("presc.t", 12, 0, 2);
    chk("presc.pm", 32'(pm), 0);

    // Day wrap and display mapping.
    en = 1'b0; mode_24h = 1'b1;
    do_set(23, 59, 58, 1'b0);
    chk_time("set24", 23, 59, 58);
    chk("set24.err", 32'(set_err), 0);
    mode_24h = 1'b0; #1;
    chk("disp12.h23", 32'(hours), 11);
    chk("disp12.pm23", 32'(pm), 1);
    mode_24h = 1'b1; en = 1'b1;
    cyc(4);
    chk_time("wrap.a", 23, 59, 59);
    cyc(4);
    chk_time("wrap.b", 0, 0, 0);
    mode_24h = 1'b0; #1;
    chk_time("wrap12", 12, 0, 0);
    chk("wrap12.pm", 32'(pm), 0);
    do_set(11, 59, 59, 1'b0);
    chk("set12.h", 32'(hours), 11);
    chk("set12.pm", 32'(pm), 0);
    cyc(4);
    chk_time("noon", 12, 0, 0);
    chk("noon.pm", 32'(pm), 1);

    // Invalid sets: error pulse, time unchanged.
    en = 1'b0;
    do_set(0, 0, 0, 1'b0);
    chk("bad.h0.err", 32'(set_err), 1);
    chk_time("bad.h0", 12, 0, 0);
    cyc(1);
    chk("bad.err_pulse", 32'(set_err), 0);
    do_set(5, 60, 0, 1'b0);
    chk("bad.m60.err", 32'(set_err), 1);
    chk_time("bad.m60", 12, 0, 0);
    cyc(1);
    mode_24h = 1'b1;
    do_set(24, 0, 0, 1'b0);
    chk("bad.h24.err", 32'(set_err), 1);
    chk_time("bad.h24", 12, 0, 0);
    cyc(1);

    // Set coinciding with a tick: set wins, prescaler restarts.
    en = 1'b1;
    cyc(3);
    do_set(6, 59, 59, 1'b0);
    chk_time("setwin", 6, 59, 59);
    chk("setwin.tick", 32'(sec_tick), 0);
    cyc(3);
    chk_time("setwin.hold", 6, 59, 59);
    cyc(1);
    chk_time("setwin.adv", 7, 0, 0);
    chk("setwin.tick2", 32'(sec_tick), 1);

    // Alarm at 07:00 written alongside a time set.
    alarm_arm = 1'b1; alarm_wr = 1'b1; alarm_hours = 5'd7; alarm_minutes = 6'd0;
    do_set(6, 59, 59, 1'b0);
    alarm_wr = 1'b0;
    chk("alm.wr_err", 32'(set_err), 0);
    cyc(3);
    chk("alm.early", 32'(alarm_fire), 0);
    cyc(1);
    chk("alm.fire", 32'(alarm_fire), 1);
    chk("alm.tick", 32'(sec_tick), 1);
    chk("alm.pending", 32'(alarm_pending), 1);
    cyc(1);
    chk("alm.fire_pulse", 32'(alarm_fire), 0);
    do_set(6, 59, 59, 1'b0);
    cyc(4);
    chk("alm.fire2", 32'(alarm_fire), 1);
    alarm_ack = 1'b1;
    cyc(1);
    alarm_ack = 1'b0;
    chk("alm.ack_vs_fire", 32'(alarm_pending), 1);
    alarm_ack = 1'b1;
    cyc(1);
    alarm_ack = 1'b0;
    chk("alm.ack", 32'(alarm_pending), 0);

    alarm_arm = 1'b0;
    do_set(6, 59, 59, 1'b0);
    cyc(4);
    chk("alm.disarm.tick", 32'(sec_tick), 1);
    chk("alm.disarm.fire", 32'(alarm_fire), 0);
    chk("alm.disarm.pend", 32'(alarm_pending), 0);

    alarm_arm = 1'b1;
    do_set(7, 0, 0, 1'b0);
    chk_time("alm.direct", 7, 0, 0);
    chk("alm.direct.fire", 32'(alarm_fire), 0);
    cyc(1);
    chk("alm.direct.fire2", 32'(alarm_fire), 0);

    // Rejected alarm write keeps 07:00.
    alarm_wr = 1'b1; alarm_hours = 5'd25; alarm_minutes = 6'd30;
    cyc(1);
    alarm_wr = 1'b0;
    chk("alm.bad.err", 32'(set_err), 1);
    do_set(6, 59, 59, 1'b0);
    cyc(4);
    chk("alm.kept.fire", 32'(alarm_fire), 1);

    // Enable low holds time and prescaler.
    do_set(10, 20, 30, 1'b0);
    cyc(2);
    en = 1'b0;
    cyc(20);
    chk_time("hold", 10, 20, 30);
    chk("hold.tick", 32'(sec_tick), 0);
    en = 1'b1;
    cyc(1);
    chk("hold.s", 32'(seconds), 30);
    cyc(1);
    chk("hold.resume", 32'(seconds), 31);
    chk("hold.resume_tick", 32'(sec_tick), 1);

    // Mid-run reset.
    chk("prereset.pending", 32'(alarm_pending), 1);
    rst = 1'b1;
    cyc(1);
    chk_time("rst2", 0, 0, 0);
    chk("rst2.pending", 32'(alarm_pending), 0);
    chk("rst2.fire", 32'(alarm_fire), 0);
    chk("rst2.tick", 32'(sec_tick), 0);
    chk("rst2.err", 32'(set_err), 0);
    mode_24h = 1'b0; #1;
    chk("rst2.h12", 32'(hours), 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
